// File: rtl/dispatch_ctrl_pkg.sv
// Shared decode/dispatch definitions: decoded-instruction record, FU class and
// the dispatch sequencing FSM states.
package dispatch_ctrl_pkg;

    localparam int DISPQUE_NUM = 4;

    typedef enum logic [1:0] {
        FU_ALU,
        FU_MUL,
        FU_LSU,
        FU_BRU
    } Fu_t;

    typedef struct packed {
        logic [7:0] pc;
        Fu_t        fu;
        logic [1:0] dispQue_id;
        logic       need_serialize;
    } decinfo_t;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_SOLO,
        ST_WAIT
    } disp_state_t;

endpackage

// File: rtl/dispatch_ctrl_steer_select.sv
// In-order steering of buffered slots into dispatch queues under per-queue
// credits; purely combinational.
module disp_steer_select
    import dispatch_ctrl_pkg::*;
#(
    parameter int DECWIDTH = 4,
    parameter int QUE_NUM  = DISPQUE_NUM,
    parameter int FREEW    = 3,
    parameter int IDXW     = $clog2(DECWIDTH)
) (
    input  logic [DECWIDTH-1:0]                buf_vld,
    input  logic [DECWIDTH-1:0][1:0]           que_id,
    input  logic [DECWIDTH-1:0]                ser,
    input  logic [QUE_NUM-1:0][FREEW-1:0]      que_free,
    output logic [DECWIDTH-1:0]                disp_mask,
    output logic [DECWIDTH-1:0][IDXW-1:0]      que_idx,
    output logic                               ser_stop
);

    logic [FREEW-1:0] usage [QUE_NUM];
    logic             blocked;

    always_comb begin
        for (int q = 0; q < QUE_NUM; q++) usage[q] = '0;
        blocked   = 1'b0;
        disp_mask = '0;
        que_idx   = '0;
        ser_stop  = 1'b0;
        // The first slot that cannot go ends the scan, keeping dispatch in order.
        for (int i = 0; i < DECWIDTH; i++) begin
            if (buf_vld[i] && !blocked) begin
                if (ser[i]) begin
                    blocked  = 1'b1;
                    ser_stop = 1'b1;
                end else if (usage[que_id[i]] < que_free[que_id[i]]) begin
                    disp_mask[i]     = 1'b1;
                    que_idx[i]       = usage[que_id[i]][IDXW-1:0];
                    usage[que_id[i]] = usage[que_id[i]] + FREEW'(1);
                end else begin
                    blocked = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/dispatch_ctrl.sv
// Decode-to-dispatch sequencer: buffers one decode group, steers it in order
// into the dispatch queues and serializes need_serialize instructions.
module dispatch_ctrl
    import dispatch_ctrl_pkg::*;
#(
    parameter int DECWIDTH = 4,
    parameter int QUE_NUM  = DISPQUE_NUM,
    parameter int FREEW    = 3
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      i_squash,
    input  logic [DECWIDTH-1:0]                       i_dec_vld,
    input  decinfo_t [DECWIDTH-1:0]                   i_decinfo,
    output logic                                      o_dec_rdy,
    input  logic [QUE_NUM-1:0][FREEW-1:0]             i_que_free,
    output logic [QUE_NUM-1:0][DECWIDTH-1:0]          o_que_wen,
    output decinfo_t [QUE_NUM-1:0][DECWIDTH-1:0]      o_que_data,
    input  logic                                      i_rob_empty,
    output logic                                      o_ser_busy
);

    localparam int IDXW = $clog2(DECWIDTH);

    disp_state_t                    state, state_nxt;
    decinfo_t                       buf_data [DECWIDTH];
    logic [DECWIDTH-1:0]            buf_vld;
    logic [DECWIDTH-1:0][1:0]       que_id;
    logic [DECWIDTH-1:0]            ser;
    logic [DECWIDTH-1:0]            sel_mask;
    logic [DECWIDTH-1:0][IDXW-1:0]  sel_idx;
    logic                           ser_stop;
    logic [DECWIDTH-1:0]            disp;
    logic [DECWIDTH-1:0][IDXW-1:0]  slot_idx;
    logic [IDXW-1:0]                head;
    logic [1:0]                     head_q;
    logic                           solo_ok;
    logic                           rdy;
    logic                           accept;

    always_comb begin
        for (int i = 0; i < DECWIDTH; i++) begin
            que_id[i] = buf_data[i].dispQue_id;
            ser[i]    = buf_data[i].need_serialize;
        end
    end

    disp_steer_select #(
        .DECWIDTH (DECWIDTH),
        .QUE_NUM  (QUE_NUM),
        .FREEW    (FREEW),
        .IDXW     (IDXW)
    ) u_steer (
        .buf_vld   (buf_vld),
        .que_id    (que_id),
        .ser       (ser),
        .que_free  (i_que_free),
        .disp_mask (sel_mask),
        .que_idx   (sel_idx),
        .ser_stop  (ser_stop)
    );

    // Oldest remaining slot; only it can be the serializing one in SOLO.
    always_comb begin
        head = '0;
        for (int i = DECWIDTH - 1; i >= 0; i--) begin
            if (buf_vld[i]) head = IDXW'(i);
        end
        head_q  = buf_data[head].dispQue_id;
        solo_ok = buf_vld[head] && (i_que_free[head_q] != '0);
    end

    always_comb begin
        state_nxt = state;
        disp      = '0;
        slot_idx  = sel_idx;
        rdy       = 1'b0;
        case (state)
            ST_RUN: begin
                disp = sel_mask;
                rdy  = (sel_mask == buf_vld);
                if (ser_stop) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (i_rob_empty) state_nxt = ST_DRAIN == state ? ST_SOLO : state;
            end
            ST_SOLO: begin
                slot_idx = '0;
                if (solo_ok) disp[head] = 1'b1;
                if (solo_ok || !(|buf_vld)) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_rob_empty) state_nxt = ST_RUN;
            end
            default: state_nxt = ST_RUN;
        endcase
        if (i_squash) begin
            disp      = '0;
            rdy       = 1'b0;
            state_nxt = ST_RUN;
        end
    end

    assign o_dec_rdy  = rdy;
    assign o_ser_busy = (state != ST_RUN);
    assign accept     = (|i_dec_vld) && rdy;

    // Data lanes are zero wherever no write is issued.
    always_comb begin
        o_que_wen  = '0;
        o_que_data = '0;
        for (int q = 0; q < QUE_NUM; q++) begin
            for (int i = 0; i < DECWIDTH; i++) begin
                if (disp[i] && (que_id[i] == 2'(q))) begin
                    o_que_wen[q][slot_idx[i]]  = 1'b1;
                    o_que_data[q][slot_idx[i]] = buf_data[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_RUN;
            buf_vld <= '0;
        end else begin
            state <= state_nxt;
            if (i_squash)    buf_vld <= '0;
            else if (accept) buf_vld <= i_dec_vld;
            else             buf_vld <= buf_vld & ~disp;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < DECWIDTH; i++) buf_data[i] <= i_decinfo[i];
        end
    end

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Directed bench for dispatch_ctrl: steering, credits, serialization,
// squash and asynchronous reset.
module tb_dispatch_ctrl;
    import dispatch_ctrl_pkg::*;

    logic                      clk;
    logic                      rst;
    logic                      i_squash;
    logic [3:0]                i_dec_vld;
    decinfo_t [3:0]            i_decinfo;
    logic                      o_dec_rdy;
    logic [3:0][2:0]           i_que_free;
    logic [3:0][3:0]           o_que_wen;
    decinfo_t [3:0][3:0]       o_que_data;
    logic                      i_rob_empty;
    logic                      o_ser_busy;

    int n_checks = 0;
    int n_errors = 0;

    dispatch_ctrl #(.DECWIDTH(4), .QUE_NUM(4), .FREEW(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_squash    (i_squash),
        .i_dec_vld   (i_dec_vld),
        .i_decinfo   (i_decinfo),
        .o_dec_rdy   (o_dec_rdy),
        .i_que_free  (i_que_free),
        .o_que_wen   (o_que_wen),
        .o_que_data  (o_que_data),
        .i_rob_empty (i_rob_empty),
        .o_ser_busy  (o_ser_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic wens(input string tag, input logic [3:0] e0, input logic [3:0] e1,
                        input logic [3:0] e2, input logic [3:0] e3);
        chk({tag, "_wen_q0"}, 32'(o_que_wen[0]), 32'(e0));
        chk({tag, "_wen_q1"}, 32'(o_que_wen[1]), 32'(e1));
        chk({tag, "_wen_q2"}, 32'(o_que_wen[2]), 32'(e2));
        chk({tag, "_wen_q3"}, 32'(o_que_wen[3]), 32'(e3));
    endtask

    function automatic decinfo_t mk(input int pc, input int q, input logic s);
        decinfo_t d;
        d.pc             = 8'(pc);
        d.fu             = FU_ALU;
        d.dispQue_id     = 2'(q);
        d.need_serialize = s;
        return d;
    endfunction

    task automatic grp(input logic [3:0] vld, input int q0, input int q1, input int q2,
                       input int q3, input logic [3:0] s, input int pc0);
        i_dec_vld    = vld;
        i_decinfo[0] = mk(pc0,     q0, s[0]);
        i_decinfo[1] = mk(pc0 + 1, q1, s[1]);
        i_decinfo[2] = mk(pc0 + 2, q2, s[2]);
        i_decinfo[3] = mk(pc0 + 3, q3, s[3]);
    endtask

    task automatic cyc;
        @(negedge clk);
    endtask

    task automatic settle;
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        i_squash    = 1'b0;
        i_rob_empty = 1'b0;
        i_que_free  = {4{3'd4}};
        grp(4'b0000, 0, 0, 0, 0, 4'b0000, 0);
        settle;
        wens("rst", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        chk("rst_rdy",  32'(o_dec_rdy),   1);
        chk("rst_busy", 32'(o_ser_busy),  0);
        chk("rst_data", 32'(|o_que_data), 0);
        cyc; rst = 1'b0;

        // full-width steer and back-to-back group
        grp(4'b1111, 0, 1, 1, 2, 4'b0000, 10); settle;
        chk("fw_rdy_empty", 32'(o_dec_rdy), 1);
        cyc; grp(4'b0011, 3, 3, 0, 0, 4'b0000, 20); settle;
        wens("fw", 4'b0001, 4'b0011, 4'b0001, 4'b0000);
        chk("fw_q1k1_pc", 32'(o_que_data[1][1].pc), 12);
        chk("fw_q2k0_pc", 32'(o_que_data[2][0].pc), 13);
        chk("fw_rdy",     32'(o_dec_rdy), 1);
        cyc; i_dec_vld = 4'b0000; settle;
        wens("b2b", 4'b0000, 4'b0000, 4'b0000, 4'b0011);
        chk("b2b_q3k1_pc", 32'(o_que_data[3][1].pc), 21);
        chk("b2b_rdy",     32'(o_dec_rdy), 1);
        cyc; settle;
        wens("idle", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // credit block on queue 1
        grp(4'b1111, 1, 1, 1, 0, 4'b0000, 30); i_que_free[1] = 3'd2; settle;
        cyc; i_dec_vld = 4'b0000; settle;
        wens("cb1", 4'b0000, 4'b0011, 4'b0000, 4'b0000);
        chk("cb1_rdy", 32'(o_dec_rdy), 0);
        cyc; settle;
        wens("cb2", 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        chk("cb2_q1_pc", 32'(o_que_data[1][0].pc), 32);
        chk("cb2_q0_pc", 32'(o_que_data[0][0].pc), 33);
        chk("cb2_rdy",   32'(o_dec_rdy), 1);
        cyc; i_que_free = {4{3'd4}}; settle;
        wens("cb3", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // serializing slot 1
        grp(4'b1111, 0, 1, 2, 3, 4'b0010, 40); settle;
        cyc; i_dec_vld = 4'b0000; settle;
        wens("ser_run", 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        chk("ser_run_busy", 32'(o_ser_busy), 0);
        chk("ser_run_rdy",  32'(o_dec_rdy), 0);
        cyc; settle;
        wens("ser_drain1", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        chk("ser_drain1_busy", 32'(o_ser_busy), 1);
        cyc; settle;
        wens("ser_drain2", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        chk("ser_drain2_busy", 32'(o_ser_busy), 1);
        cyc; i_rob_empty = 1'b1; settle;
        wens("ser_drain3", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        chk("ser_drain3_busy", 32'(o_ser_busy), 1);
        cyc; i_rob_empty = 1'b0; settle;
        wens("ser_solo", 4'b0000, 4'b0001, 4'b0000, 4'b0000);
        chk("ser_solo_pc",   32'(o_que_data[1][0].pc), 41);
        chk("ser_solo_busy", 32'(o_ser_busy), 1);
        chk("ser_solo_rdy",  32'(o_dec_rdy), 0);
        cyc; settle;
        wens("ser_wait1", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        chk("ser_wait1_busy", 32'(o_ser_busy), 1);
        cyc; i_rob_empty = 1'b1; settle;
        wens("ser_wait2", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        cyc; i_rob_empty = 1'b0; settle;
        wens("ser_tail", 4'b0000, 4'b0000, 4'b0001, 4'b0001);
        chk("ser_tail_pc2", 32'(o_que_data[2][0].pc), 42);
        chk("ser_tail_pc3", 32'(o_que_data[3][0].pc), 43);
        chk("ser_tail_busy", 32'(o_ser_busy), 0);
        chk("ser_tail_rdy",  32'(o_dec_rdy), 1);

        // squash while draining
        grp(4'b0011, 0, 1, 0, 0, 4'b0001, 50); settle;
        cyc; i_dec_vld = 4'b0000; settle;
        wens("sq_run", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        chk("sq_run_rdy", 32'(o_dec_rdy), 0);
        cyc; settle;
        chk("sq_drain_busy", 32'(o_ser_busy), 1);
        cyc; i_squash = 1'b1; i_rob_empty = 1'b1; settle;
        wens("sq_cyc", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        chk("sq_cyc_rdy", 32'(o_dec_rdy), 0);
        cyc; i_squash = 1'b0; i_rob_empty = 1'b0; settle;
        chk("sq_after_busy", 32'(o_ser_busy), 0);
        chk("sq_after_rdy",  32'(o_dec_rdy), 1);
        wens("sq_after", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // squash overrides an offered group
        i_squash = 1'b1; grp(4'b0001, 0, 0, 0, 0, 4'b0000, 55); settle;
        chk("sq_acc_rdy", 32'(o_dec_rdy), 0);
        cyc; i_squash = 1'b0; i_dec_vld = 4'b0000; settle;
        wens("sq_noacc", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        chk("sq_noacc_rdy", 32'(o_dec_rdy), 1);

        // asynchronous reset during SOLO
        i_rob_empty = 1'b1; grp(4'b0001, 2, 0, 0, 0, 4'b0001, 60); settle;
        cyc; i_dec_vld = 4'b0000; settle;
        chk("ar_run_busy", 32'(o_ser_busy), 0);
        cyc; settle;
        chk("ar_drain_busy", 32'(o_ser_busy), 1);
        wens("ar_drain", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        cyc; settle;
        wens("ar_solo", 4'b0000, 4'b0000, 4'b0001, 4'b0000);
        chk("ar_solo_busy", 32'(o_ser_busy), 1);
        #2; rst = 1'b1; #1;
        wens("arst", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        chk("arst_busy", 32'(o_ser_busy),  0);
        chk("arst_rdy",  32'(o_dec_rdy),   1);
        chk("arst_data", 32'(|o_que_data), 0);
        cyc; rst = 1'b0; i_rob_empty = 1'b0; settle;
        wens("arst_drop", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        chk("arst_drop_rdy", 32'(o_dec_rdy), 1);

        // zero credit on queue 0 holds the whole group
        i_que_free[0] = 3'd0; grp(4'b0011, 0, 1, 0, 0, 4'b0000, 70); settle;
        cyc; i_dec_vld = 4'b0000; settle;
        wens("zc1", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        chk("zc1_rdy", 32'(o_dec_rdy), 0);
        cyc; settle;
        wens("zc2", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        cyc; i_que_free[0] = 3'd1; settle;
        wens("zc3", 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        chk("zc3_pc",  32'(o_que_data[0][0].pc), 70);
        chk("zc3_rdy", 32'(o_dec_rdy), 1);
        cyc; i_que_free = {4{3'd4}}; settle;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dispatch_ctrl.md
# dispatch_ctrl

Sequencing controller between decode and the dispatch queues. It latches one decoded group of up to DECWIDTH `decinfo_t` entries and steers each valid entry, in program order, into the dispatch queue selected by its `dispQue_id`, limited by per-queue free-entry credits. It enforces `need_serialize`:
- the pipeline drains before a serializing instruction is dispatched;
- that instruction is dispatched alone;
- younger instructions are held until it has committed.

## Interface
Parameters:
- DECWIDTH, 4: decode group width (slots per cycle)
- QUE_NUM, 4: number of dispatch queues; must match the 2-bit `dispQue_id`
- FREEW, 3: width of per-queue free count; saturates at DECWIDTH

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, asynchronous, active-high
- i_squash  in  1  pipeline flush; highest priority
- i_dec_vld  in  DECWIDTH  per-slot valid of offered group; valid slots are a contiguous prefix
- i_decinfo  in  DECWIDTH x decinfo_t  offered group
- o_dec_rdy  out  1  group accepted at this edge when `|i_dec_vld & o_dec_rdy`
- i_que_free  in  QUE_NUM x FREEW  free entries per dispatch queue this cycle
- o_que_wen  out  QUE_NUM x DECWIDTH  per-queue write enables, compacted: bit k = k-th write to that queue
- o_que_data  out  QUE_NUM x DECWIDTH x decinfo_t  matching data
- i_rob_empty  in  1  ROB holds no uncommitted instructions
- o_ser_busy  out  1  state is not RUN

## Operation
- **Internal buffer**: DECWIDTH entries plus `buf_vld` mask. An accepted group is copied into the buffer with `buf_vld = i_dec_vld`. An entry's `buf_vld` bit clears when that entry is dispatched.
- **Dispatch selection (RUN)**:
  - Scan buffer slots oldest-first.
  - Per-queue usage counters start at 0 each cycle.
  - A slot dispatches if its queue's usage < `i_que_free[q]`, and it is not serializing, and all older valid slots dispatched this cycle.
  - The first blocked slot stops the scan. There is no out-of-order dispatch.
  - A slot with `need_serialize=1` stops the scan. Once it is the oldest remaining slot, the FSM goes to DRAIN.
- **o_dec_rdy**: 1 when every remaining `buf_vld` slot dispatches this cycle (or the buffer is empty), the state is RUN, and i_squash=0. This gives back-to-back groups at full throughput.
- **FSM states and transitions**:
  - RUN: as above.
  - DRAIN: no dispatch. Go to SOLO when `i_rob_empty=1`.
  - SOLO: dispatch the oldest (serializing) slot alone when its queue has ≥1 free entry. Go to WAIT.
  - WAIT: no dispatch. Go to RUN when `i_rob_empty=1`, i.e. the serializing instruction has committed.
- The serializing instruction's `o_que_wen` pulse occurs only in SOLO. Younger slots of the same group dispatch in RUN after WAIT.
- **i_squash**:
  - Same cycle: `o_que_wen=0`, `o_dec_rdy=0`.
  - Next edge: `buf_vld` cleared, state forced to RUN.
  - i_squash overrides a simultaneous accept.
- **Credit arithmetic**: usage counters are FREEW bits wide and compare unsigned against `i_que_free`. `i_que_free=0` blocks that queue entirely.

## Timing
- **Reset values**: `buf_vld=0`, state=RUN, `o_que_wen=0`, `o_ser_busy=0`, `o_dec_rdy=1`, `o_que_data=0`.
- **Latency**: a group accepted at edge N dispatches from cycle N+1 at the earliest.
- **o_que_wen/o_que_data** are combinational from the buffer, state and `i_que_free`. Queues sample them at the next edge.
- **Serialization timeline**: DRAIN lasts ≥1 cycle even if `i_rob_empty` is already 1. SOLO lasts ≥1 cycle. WAIT lasts ≥1 cycle.
- **Reset mid-operation**: asynchronous clear to the reset values above. Any partially dispatched group is dropped.
- **Simultaneous squash and SOLO dispatch**: squash wins and no write is issued.

## Structure
- Shared package: dispatch FSM state enum (RUN, DRAIN, SOLO, WAIT) and the `DISPQUE_NUM` constant, next to `decinfo_t`/`Fu_t` in the decode definitions.
- One sub-module, `disp_steer_select`: purely combinational. Inputs are `buf_vld`, queue ids, serialize flags and `i_que_free`. It produces the per-slot dispatch mask and per-queue compacted index.
- `dispatch_ctrl` holds the buffer, FSM and output muxing.
- Expected size is about 250 lines.

## Test plan
- **Full-width steer**: 4 slots with que ids 0,1,1,2; all free=4 → cycle after accept: que0 wen=0001, que1 wen=0011 (slots 1,2 in order), que2 wen=0001; `o_dec_rdy=1` for a back-to-back next group.
- **Credit block**: que ids 1,1,1,0 with que1 free=2 → first cycle dispatches slots 0,1 only; slot 3 is held (in order) with `o_dec_rdy=0`; next cycle with free=2 → slots 2,3 dispatch and `o_dec_rdy=1`.
- **Serialize**: slot 1 has `need_serialize=1`, `i_rob_empty=0` for 3 cycles → slot 0 dispatches, then DRAIN holds with `o_ser_busy=1`; `i_rob_empty=1` → SOLO writes slot 1 only; WAIT until `i_rob_empty=1`; then slots 2,3 dispatch.
- **Squash mid-DRAIN**: assert i_squash → no wen that cycle; next cycle state=RUN, `buf_vld=0`, `o_dec_rdy=1`.
- **Async reset** asserted between edges during SOLO → outputs reach reset values without a clock edge.
- **Zero credit**: que0 free=0 with slot 0→que0 → no writes for any slot until free≥1.
